// File: rtl/tetris_pkg.sv
// tetris_pkg: shared board geometry, line-clear FSM encoding, score weights and row helpers.
// Revision 1.0
`default_nettype none

package tetris_pkg;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int BOARD_W = COLS * ROWS;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] WEIGHT_1 = 4'd1;
  localparam logic [3:0] WEIGHT_2 = 4'd3;
  localparam logic [3:0] WEIGHT_3 = 4'd5;
  localparam logic [3:0] WEIGHT_4 = 4'd8;

  function automatic logic row_full(input logic [0:BOARD_W-1] board, input logic [4:0] r);
    logic full;
    full = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      if (r == i[4:0]) full = &board[i*COLS +: COLS];
    end
    return full;
  endfunction

  function automatic logic [3:0] score_weight(input logic [4:0] n);
    logic [3:0] w;
    case (n)
      5'd0:    w = 4'd0;
      5'd1:    w = WEIGHT_1;
      5'd2:    w = WEIGHT_2;
      5'd3:    w = WEIGHT_3;
      default: w = WEIGHT_4;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/board_row_sel.sv
// board_row_sel: combinational extraction of one COLS-bit row from a packed board.
// Revision 1.0
`default_nettype none

module board_row_sel
  import tetris_pkg::*;
(
  input  logic [0:BOARD_W-1] board,
  input  logic [4:0]         row,
  output logic [0:COLS-1]    bits
);

  always_comb begin
    bits = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row == r[4:0]) bits = board[r*COLS +: COLS];
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_clear.sv
// line_clear: multi-cycle bottom-up full-row removal and compaction; optional score output under LINE_CLEAR_SCORE_EN.
// Revision 1.0
`default_nettype none

module line_clear
  import tetris_pkg::*;
#(
  parameter int TOT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [0:BOARD_W-1] board_in,
  output logic [0:BOARD_W-1] board_out,
  output logic               busy,
  output logic               done,
  output logic [4:0]         lines_cleared,
`ifdef LINE_CLEAR_SCORE_EN
  output logic [15:0]        score,
`endif
  output logic [TOT_W-1:0]   lines_total
);

  state_t             state, next_state;
  logic [0:BOARD_W-1] work;
  logic [0:BOARD_W-1] scan_buf;
  logic [0:BOARD_W-1] filled;
  logic [4:0]         rd, wr, cnt;
  logic [0:COLS-1]    rd_row;
  logic               rd_full;
  logic [TOT_W:0]     total_sum;
  logic [TOT_W-1:0]   total_next;

  board_row_sel u_rd_sel (
    .board (work),
    .row   (rd),
    .bits  (rd_row)
  );

  assign rd_full = row_full(work, rd);

  always_comb begin
    scan_buf = work;
    for (int r = 0; r < ROWS; r++) begin
      if (wr == r[4:0]) scan_buf[r*COLS +: COLS] = rd_row;
    end
  end

  // With no rows removed wr has wrapped to 31, so the clear range is gated on cnt.
  always_comb begin
    filled = work;
    for (int r = 0; r < ROWS; r++) begin
      if ((cnt != 5'd0) && (r[4:0] <= wr)) filled[r*COLS +: COLS] = '0;
    end
  end

  assign total_sum  = {1'b0, lines_total} + (TOT_W+1)'(cnt);
  assign total_next = total_sum[TOT_W] ? {TOT_W{1'b1}} : total_sum[TOT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_SCAN;
      S_SCAN:  if (rd == 5'd0) next_state = S_FILL;
      S_FILL:  next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work          <= '0;
      rd            <= '0;
      wr            <= '0;
      cnt           <= '0;
      board_out     <= '0;
      lines_cleared <= '0;
      lines_total   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            work <= board_in;
            rd   <= LAST_ROW;
            wr   <= LAST_ROW;
            cnt  <= '0;
          end
        end
        S_SCAN: begin
          rd <= rd - 5'd1;
          if (rd_full) begin
            cnt <= cnt + 5'd1;
          end else begin
            work <= scan_buf;
            wr   <= wr - 5'd1;
          end
        end
        S_FILL: begin
          work          <= filled;
          board_out     <= filled;
          lines_cleared <= cnt;
          lines_total   <= total_next;
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + 17'(score_weight(cnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               score <= '0;
    else if (state == S_FILL) score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
`endif

endmodule

`default_nettype wire
